// File: rtl/pc_reg.sv
// Program-counter register: bus-loaded, tri-state bus readback, always-driven o_pc copy.
// Optional macro PC_REG_AUTOINC_EN: selected-but-not-written edges increment the register.
module pc_reg #(
    parameter int          WORD_SIZE   = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_data_in,
    input  logic                 i_cs,
    input  logic                 i_we,
    input  logic                 i_oe,
    output tri   [WORD_SIZE-1:0] o_data_out,
    output logic [WORD_SIZE-1:0] o_pc
);

    localparam logic [WORD_SIZE-1:0] RST_VAL = RESET_VALUE[WORD_SIZE-1:0];

    logic [WORD_SIZE-1:0] r_pc;
    logic                 w_load;
    logic                 w_drive;

    assign w_load  = i_cs & i_we;
    assign w_drive = i_cs & i_oe;

`ifdef PC_REG_AUTOINC_EN
    logic                 w_inc;
    logic [WORD_SIZE-1:0] w_pc_inc;

    // Load wins over increment; the sum wraps naturally at 2^WORD_SIZE.
    assign w_inc    = i_cs & ~i_we;
    assign w_pc_inc = r_pc + WORD_SIZE'(1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc <= RST_VAL;
        end else if (w_load) begin
            r_pc <= i_data_in;
        end else if (w_inc) begin
            r_pc <= w_pc_inc;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc <= RST_VAL;
        end else if (w_load) begin
            r_pc <= i_data_in;
        end
    end
`endif

    // Readback comes from the register only, so a same-cycle load is not bypassed.
    assign o_data_out = w_drive ? r_pc : {WORD_SIZE{1'bz}};
    assign o_pc       = r_pc;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed vectors, an edge-level behavioural model
// and a negedge compare process, plus literal checks that pin the model.
module tb_pc_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         cs;
  logic         we;
  logic         oe;
  wire  [W-1:0] data_out;
  logic [W-1:0] pc;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [W-1:0] exp_pc;
  bit           chk_en = 0;

  pc_reg #(.WORD_SIZE(W), .RESET_VALUE(32'd0)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_in  (data_in),
    .i_cs       (cs),
    .i_we       (we),
    .i_oe       (oe),
    .o_data_out (data_out),
    .o_pc       (pc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bus_view(input logic [W-1:0] value);
    logic [W-1:0] zz;
    zz = 'z;
    return (cs === 1'b1 && oe === 1'b1) ? value : zz;
  endfunction

  // Model of one rising edge, stated as the register's rules.
  task automatic model_edge();
    if (rst == 1'b0)
      exp_pc = 8'h00;
    else if (cs && we)
      exp_pc = data_in;
`ifdef PC_REG_AUTOINC_EN
    else if (cs)
      exp_pc = W'((int'(exp_pc) + 1) % 256);
`endif
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc", pc, exp_pc);
      check("cyc_bus", data_out, bus_view(exp_pc));
    end
  end

  // driver tasks: inputs change 1 time unit after the falling edge
  task automatic drive(input logic r, input logic c, input logic w, input logic o, input logic [W-1:0] d);
    rst = r; cs = c; we = w; oe = o; data_in = d;
    if (r == 1'b0) exp_pc = 8'h00;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
    end
  endtask

  logic [W-1:0] zz_c;

  initial begin
    zz_c = 'z;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_bus", data_out, 8'h00);
    @(negedge clk); #1;
    chk_en = 1;
    tick(2);
    check("rst_hold", pc, 8'h00);

    // release then first load
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
    tick();
    check("load_3c", pc, 8'h3C);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h81);
    tick();
`ifdef PC_REG_AUTOINC_EN
    check("we0_inc", pc, 8'h3D);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
    tick();
`else
    check("we0_hold", pc, 8'h3C);
`endif

    // output gating with register = 0x3C
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    cs = 1'b1; oe = 1'b0; #1;
    check("gate_cs1_oe0", data_out, zz_c);
    oe = 1'b1; #1;
    check("gate_cs1_oe1", data_out, 8'h3C);
    cs = 1'b0; #1;
    check("gate_cs0_oe1", data_out, zz_c);
    check("gate_pc", pc, 8'h3C);
    tick(2);

    // no bypass: old value shown until the edge
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
    #1;
    check("nobypass_old", data_out, 8'h3C);
    tick();
    check("nobypass_new", data_out, 8'h5A);

    // async reset mid-cycle with register = 0x5A
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    #1;
    check("async_pc", pc, 8'h00);
    check("async_bus", data_out, 8'h00);
    tick();
    check("async_hold", pc, 8'h00);

    // reset mid-operation: new data every 3 clocks, reset toggles every 10
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int c = 0; c < 60; c++) begin
      logic [W-1:0] d;
      logic         r;
      d = data_in;
      r = rst;
      if (c % 3 == 0) d = W'($urandom_range(0, 255));
      if (c % 10 == 0 && c != 0) r = ~rst;
      drive(r, 1'b1, 1'b1, 1'b1, d);
      tick();
      if (rst == 1'b1) check("midop_load", pc, d);
      else             check("midop_rst", pc, 8'h00);
    end

    // deselect with write enable active
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    tick(4);
    check("desel_pc", pc, 8'h3C);
    check("desel_bus", data_out, zz_c);

    // increment / hold sequence from 0xFE
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
`ifdef PC_REG_AUTOINC_EN
    tick(); check("inc_ff", pc, 8'hFF);
    tick(); check("inc_00", pc, 8'h00);
    tick(); check("inc_01", pc, 8'h01);
`else
    tick(3); check("hold_fe", pc, 8'hFE);
`endif
    we = 1'b1;
    tick();
    check("load_10", pc, 8'h10);
    cs = 1'b0; we = 1'b0;
    tick(2);
    check("cs0_hold", pc, 8'h10);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
